nunchuck_frame_rx: RTL and testbench



---
 rtl/nunchuck_frame_rx_pkg.sv | 21 ++
 rtl/nunchuck_frame_rx_if.sv | 23 ++
 rtl/nunchuck_frame_rx_gap_timer.sv | 25 ++
 rtl/nunchuck_frame_rx.sv | 161 ++++++++++++++++
 tb/tb_nunchuck_frame_rx.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/nunchuck_frame_rx_pkg.sv
// Shared types and constants for the nunchuck frame receiver.
package nunchuck_pkg;

    typedef enum logic [2:0] {
        HUNT   = 3'd0,
        AXES   = 3'd1,
        BTN    = 3'd2,
        CKSUM  = 3'd3,
        COMMIT = 3'd4
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_CKSUM   = 2'b10;

    localparam int BTN_Z_BIT = 0;
    localparam int BTN_C_BIT = 1;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/nunchuck_frame_rx_if.sv
// Byte-in / frame-out bundle between uart_rx, the deframer and the setpoint logic.
interface nunchuck_frame_rx_if #(
    parameter int NUM_AXES = 2
);
    logic [7:0]            byte_in;
    logic                  byte_done_tick;
    logic [NUM_AXES*8-1:0] axis_vals;
    logic                  z_but;
    logic                  c_but;
    logic                  ready_tick;
    logic                  frame_err;
    logic [1:0]            err_code;

    modport master (
        output byte_in, byte_done_tick,
        input  axis_vals, z_but, c_but, ready_tick, frame_err, err_code
    );

    modport slave (
        input  byte_in, byte_done_tick,
        output axis_vals, z_but, c_but, ready_tick, frame_err, err_code
    );
endinterface

// File: rtl/nunchuck_frame_rx_gap_timer.sv
// Inter-byte gap counter; expire_o fires on the last allowed idle cycle.
module nunchuck_gap_timer #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic run_i,
    output logic expire_o
);
    localparam int             W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0]   LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       cnt_q <= '0;
        else if (clear_i) cnt_q <= '0;
        else if (run_i)   cnt_q <= cnt_q + 1'b1;
    end

    // clear_i carries the byte tick, so a tick on the expiry cycle suppresses expiry
    assign expire_o = run_i && !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/nunchuck_frame_rx.sv
// Nunchuck byte-stream deframer: sync hunt, N axis bytes, button byte, gap timeout.
// Define NUNCHUCK_CKSUM_EN to append and verify an 8-bit additive checksum byte.
module nunchuck_frame_rx
    import nunchuck_pkg::*;
#(
    parameter int         NUM_AXES       = 2,
    parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                rst_n,
    nunchuck_frame_rx_if.slave  bus
);
    localparam int               IDX_W = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_AXES - 1);

    state_e                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [NUM_AXES-1:0][7:0]   shadow_q, shadow_d;
    logic [1:0]                 btn_q, btn_d;
    logic [NUM_AXES-1:0][7:0]   axis_q;
    logic                       z_q, c_q;
    logic                       err_q, err_d;
    logic [1:0]                 code_q, code_d;
    logic                       commit;
    logic                       tick, run, expire;
`ifdef NUNCHUCK_CKSUM_EN
    logic [7:0]                 sum_q, sum_d;
`endif

    assign tick = bus.byte_done_tick;
    assign run  = (state_q == AXES) || (state_q == BTN) || (state_q == CKSUM);

    nunchuck_gap_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_gap (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (tick || !run),
        .run_i    (run),
        .expire_o (expire)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        btn_d    = btn_q;
        err_d    = 1'b0;
        code_d   = code_q;
        commit   = 1'b0;
`ifdef NUNCHUCK_CKSUM_EN
        sum_d    = sum_q;
`endif
        case (state_q)
            // COMMIT lasts one cycle and treats a byte like HUNT so back-to-back frames survive
            HUNT, COMMIT: begin
                state_d = HUNT;
                if (tick && bus.byte_in == SYNC_BYTE) begin
                    state_d = AXES;
                    idx_d   = '0;
`ifdef NUNCHUCK_CKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            AXES: begin
                if (tick) begin
                    shadow_d[idx_q] = bus.byte_in;
`ifdef NUNCHUCK_CKSUM_EN
                    sum_d = sum_q + bus.byte_in;
`endif
                    if (idx_q == LAST) state_d = BTN;
                    else               idx_d   = idx_q + 1'b1;
                end else if (expire) begin
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                    state_d = HUNT;
                end
            end
            BTN: begin
                if (tick) begin
                    btn_d = bus.byte_in[1:0];
`ifdef NUNCHUCK_CKSUM_EN
                    sum_d   = sum_q + bus.byte_in;
                    state_d = CKSUM;
`else
                    state_d = COMMIT;
                    commit  = 1'b1;
`endif
                end else if (expire) begin
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                    state_d = HUNT;
                end
            end
`ifdef NUNCHUCK_CKSUM_EN
            CKSUM: begin
                if (tick) begin
                    if (bus.byte_in == sum_q) begin
                        state_d = COMMIT;
                        commit  = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_CKSUM;
                        state_d = HUNT;
                    end
                end else if (expire) begin
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                    state_d = HUNT;
                end
            end
`endif
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HUNT;
            idx_q    <= '0;
            shadow_q <= '0;
            btn_q    <= '0;
            err_q    <= 1'b0;
            code_q   <= ERR_NONE;
`ifdef NUNCHUCK_CKSUM_EN
            sum_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            btn_q    <= btn_d;
            err_q    <= err_d;
            code_q   <= code_d;
`ifdef NUNCHUCK_CKSUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

    // Outputs load on the final accepted byte so they become visible in the COMMIT cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            axis_q <= '0;
            z_q    <= 1'b0;
            c_q    <= 1'b0;
        end else if (commit) begin
            axis_q <= shadow_d;
            z_q    <= btn_d[BTN_Z_BIT];
            c_q    <= btn_d[BTN_C_BIT];
        end
    end

    assign bus.axis_vals  = axis_q;
    assign bus.z_but      = z_q;
    assign bus.c_but      = c_q;
    assign bus.ready_tick = (state_q == COMMIT);
    assign bus.frame_err  = err_q;
    assign bus.err_code   = code_q;

endmodule

// File: tb/tb_nunchuck_frame_rx.sv
// Directed bench for nunchuck_frame_rx (NUM_AXES=2, short timeout), either checksum build.
module tb_nunchuck_frame_rx;
    localparam int TO = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   ncmp = 0;
    int   nerr = 0;
    int   ready_cnt = 0;
    int   err_cnt = 0;

    nunchuck_frame_rx_if #(.NUM_AXES(2)) bus ();

    nunchuck_frame_rx #(.NUM_AXES(2), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.ready_tick) ready_cnt++;
        if (bus.frame_err)  err_cnt++;
    end

    task automatic idle();
        @(posedge clk); #1;
    endtask

    // Called #1 after an edge; consecutive calls give ticks on consecutive cycles.
    task automatic send_byte(input logic [7:0] b);
        bus.byte_in = b;
        bus.byte_done_tick = 1'b1;
        @(posedge clk); #1;
        bus.byte_done_tick = 1'b0;
        bus.byte_in = 8'h00;
    endtask

    task automatic test_reset();
        bus.byte_in = 8'h00;
        bus.byte_done_tick = 1'b0;
        rst_n = 1'b0;
        #1;
        ncmp++; if (bus.axis_vals !== 16'h0000) begin nerr++; $display("FAIL rst_axis: got %h want 0000", bus.axis_vals); end
        ncmp++; if ({bus.z_but, bus.c_but, bus.ready_tick, bus.frame_err} !== 4'b0000) begin nerr++; $display("FAIL rst_flags: got %b want 0000", {bus.z_but, bus.c_but, bus.ready_tick, bus.frame_err}); end
        ncmp++; if (bus.err_code !== 2'b00) begin nerr++; $display("FAIL rst_code: got %b want 00", bus.err_code); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle();
    endtask

    task automatic test_clean();
        send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34); send_byte(8'h01);
`ifdef NUNCHUCK_CKSUM_EN
        ncmp++; if (bus.ready_tick !== 1'b0) begin nerr++; $display("FAIL clean_early: got %b want 0", bus.ready_tick); end
        send_byte(8'h47);
`endif
        ncmp++; if (bus.ready_tick !== 1'b1) begin nerr++; $display("FAIL clean_ready: got %b want 1", bus.ready_tick); end
        ncmp++; if (bus.axis_vals !== 16'h3412) begin nerr++; $display("FAIL clean_axis: got %h want 3412", bus.axis_vals); end
        ncmp++; if ({bus.z_but, bus.c_but, bus.frame_err} !== 3'b100) begin nerr++; $display("FAIL clean_btn: got %b want 100", {bus.z_but, bus.c_but, bus.frame_err}); end
        idle();
        ncmp++; if (bus.ready_tick !== 1'b0) begin nerr++; $display("FAIL clean_pulse: got %b want 0", bus.ready_tick); end
    endtask

    task automatic test_bad_cksum();
        int r0;
        r0 = ready_cnt;
`ifdef NUNCHUCK_CKSUM_EN
        send_byte(8'hA5); send_byte(8'h55); send_byte(8'h66); send_byte(8'h03); send_byte(8'h00);
        ncmp++; if (bus.frame_err !== 1'b1) begin nerr++; $display("FAIL bad_err: got %b want 1", bus.frame_err); end
        ncmp++; if (bus.err_code !== 2'b10) begin nerr++; $display("FAIL bad_code: got %b want 10", bus.err_code); end
        ncmp++; if (bus.axis_vals !== 16'h3412) begin nerr++; $display("FAIL bad_axis: got %h want 3412", bus.axis_vals); end
        ncmp++; if ({bus.z_but, bus.c_but} !== 2'b10) begin nerr++; $display("FAIL bad_btn: got %b want 10", {bus.z_but, bus.c_but}); end
        idle(); idle();
        ncmp++; if (ready_cnt !== r0) begin nerr++; $display("FAIL bad_noready: got %0d want %0d", ready_cnt, r0); end
        ncmp++; if (bus.frame_err !== 1'b0) begin nerr++; $display("FAIL bad_pulse: got %b want 0", bus.frame_err); end
`else
        send_byte(8'hA5); send_byte(8'h55); send_byte(8'h66); send_byte(8'h03);
        ncmp++; if (bus.ready_tick !== 1'b1) begin nerr++; $display("FAIL nock_ready: got %b want 1", bus.ready_tick); end
        ncmp++; if (bus.axis_vals !== 16'h6655) begin nerr++; $display("FAIL nock_axis: got %h want 6655", bus.axis_vals); end
        ncmp++; if ({bus.z_but, bus.c_but, bus.err_code} !== 4'b1100) begin nerr++; $display("FAIL nock_btn: got %b want 1100", {bus.z_but, bus.c_but, bus.err_code}); end
        send_byte(8'h00); idle();
        ncmp++; if (ready_cnt !== r0 + 1) begin nerr++; $display("FAIL nock_count: got %0d want %0d", ready_cnt, r0 + 1); end
`endif
    endtask

    task automatic test_garbage_sync();
        int r0;
        r0 = ready_cnt;
        send_byte(8'h00); send_byte(8'hFF); idle();
        ncmp++; if (ready_cnt !== r0) begin nerr++; $display("FAIL garb_ignored: got %0d want %0d", ready_cnt, r0); end
        send_byte(8'hA5); send_byte(8'h80); send_byte(8'h80); send_byte(8'h03);
`ifdef NUNCHUCK_CKSUM_EN
        send_byte(8'h03);
`endif
        ncmp++; if (bus.ready_tick !== 1'b1) begin nerr++; $display("FAIL garb_ready: got %b want 1", bus.ready_tick); end
        ncmp++; if (bus.axis_vals !== 16'h8080) begin nerr++; $display("FAIL garb_axis: got %h want 8080", bus.axis_vals); end
        ncmp++; if ({bus.z_but, bus.c_but} !== 2'b11) begin nerr++; $display("FAIL garb_btn: got %b want 11", {bus.z_but, bus.c_but}); end
        idle();
    endtask

    task automatic test_timeout();
        send_byte(8'hA5); send_byte(8'h12);
        repeat (TO - 1) idle();
        ncmp++; if (bus.frame_err !== 1'b0) begin nerr++; $display("FAIL to_early: got %b want 0", bus.frame_err); end
        idle();
        ncmp++; if (bus.frame_err !== 1'b1) begin nerr++; $display("FAIL to_err: got %b want 1", bus.frame_err); end
        ncmp++; if (bus.err_code !== 2'b01) begin nerr++; $display("FAIL to_code: got %b want 01", bus.err_code); end
        ncmp++; if (bus.axis_vals !== 16'h8080) begin nerr++; $display("FAIL to_axis: got %h want 8080", bus.axis_vals); end
        idle();
        send_byte(8'hA5); send_byte(8'h56); send_byte(8'h78); send_byte(8'h02);
`ifdef NUNCHUCK_CKSUM_EN
        send_byte(8'hD0);
`endif
        ncmp++; if (bus.ready_tick !== 1'b1) begin nerr++; $display("FAIL to_next_ready: got %b want 1", bus.ready_tick); end
        ncmp++; if ({bus.axis_vals, bus.z_but, bus.c_but} !== {16'h7856, 2'b01}) begin nerr++; $display("FAIL to_next_data: got %h/%b%b want 7856/01", bus.axis_vals, bus.z_but, bus.c_but); end
        idle();
    endtask

    task automatic test_back_to_back();
        int e0;
        e0 = err_cnt;
        send_byte(8'hA5); send_byte(8'h12);
        repeat (TO - 1) idle();
        send_byte(8'h34);
        ncmp++; if (bus.frame_err !== 1'b0) begin nerr++; $display("FAIL col_err: got %b want 0", bus.frame_err); end
        send_byte(8'h01);
`ifdef NUNCHUCK_CKSUM_EN
        send_byte(8'h47);
`endif
        ncmp++; if (bus.ready_tick !== 1'b1) begin nerr++; $display("FAIL col_ready: got %b want 1", bus.ready_tick); end
        ncmp++; if (bus.axis_vals !== 16'h3412) begin nerr++; $display("FAIL col_axis: got %h want 3412", bus.axis_vals); end
        ncmp++; if (err_cnt !== e0) begin nerr++; $display("FAIL col_errcnt: got %0d want %0d", err_cnt, e0); end
        ncmp++; if (bus.err_code !== 2'b01) begin nerr++; $display("FAIL col_code_hold: got %b want 01", bus.err_code); end
        // sync byte lands in the COMMIT cycle
        send_byte(8'hA5); send_byte(8'h9A); send_byte(8'hBC); send_byte(8'h00);
`ifdef NUNCHUCK_CKSUM_EN
        send_byte(8'h56);
`endif
        ncmp++; if (bus.ready_tick !== 1'b1) begin nerr++; $display("FAIL b2b_ready: got %b want 1", bus.ready_tick); end
        ncmp++; if ({bus.axis_vals, bus.z_but, bus.c_but} !== {16'hBC9A, 2'b00}) begin nerr++; $display("FAIL b2b_data: got %h/%b%b want BC9A/00", bus.axis_vals, bus.z_but, bus.c_but); end
        idle();
    endtask

    task automatic test_reset_midframe();
        int r0, e0;
        send_byte(8'hA5); send_byte(8'h12);
        rst_n = 1'b0;
        #1;
        ncmp++; if (bus.axis_vals !== 16'h0000) begin nerr++; $display("FAIL mrst_axis: got %h want 0000", bus.axis_vals); end
        ncmp++; if ({bus.z_but, bus.c_but, bus.ready_tick, bus.frame_err, bus.err_code} !== 6'b0) begin nerr++; $display("FAIL mrst_flags: got %b want 000000", {bus.z_but, bus.c_but, bus.ready_tick, bus.frame_err, bus.err_code}); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle();
        r0 = ready_cnt; e0 = err_cnt;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h00); send_byte(8'h33);
        repeat (3) idle();
        ncmp++; if (ready_cnt !== r0) begin nerr++; $display("FAIL mrst_noready: got %0d want %0d", ready_cnt, r0); end
        ncmp++; if (err_cnt !== e0) begin nerr++; $display("FAIL mrst_noerr: got %0d want %0d", err_cnt, e0); end
        ncmp++; if (bus.axis_vals !== 16'h0000) begin nerr++; $display("FAIL mrst_hold: got %h want 0000", bus.axis_vals); end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_bad_cksum();
        test_garbage_sync();
        test_timeout();
        test_back_to_back();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
